// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
//   master : datapath side; drives hazard/status inputs, receives enables/flushes.
//   slave  : controller side; the mirror image.
// Signals:
//   ifid_rs/ifid_rt, rs_used/rt_used   IF/ID source registers and their use flags
//   idex_memread, idex_wreg            load in ID/EX and its destination
//   branch_taken                       taken branch resolved in ID
//   imiss/dmiss, idone/ddone           memory busy levels and completion pulses
//   halt_wb                            HLT valid in MEM/WB
//   *_en, *_flush                      latch write enables and bubble loads
//   halted, stall_cnt                  status
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       ifid_rs;
  logic [3:0]       ifid_rt;
  logic             rs_used;
  logic             rt_used;
  logic             idex_memread;
  logic [3:0]       idex_wreg;
  logic             branch_taken;
  logic             imiss;
  logic             dmiss;
  logic             idone;
  logic             ddone;
  logic             halt_wb;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ifid_rs, ifid_rt, rs_used, rt_used, idex_memread, idex_wreg,
           branch_taken, imiss, dmiss, idone, ddone, halt_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, stall_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, rs_used, rt_used, idex_memread, idex_wreg,
           branch_taken, imiss, dmiss, idone, ddone, halt_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, instruction and
// data memory miss waits, and halt. Enables/flushes are combinational from the
// FSM state and the current inputs; a saturating counter tallies stall cycles.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pipe_hazard_ctrl_if.slave (hazard inputs, latch controls, status)
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StIwait, StDwait, StHalted} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = bus.idex_memread && (bus.idex_wreg != 4'd0) &&
                    ((bus.rs_used && (bus.ifid_rs == bus.idex_wreg)) ||
                     (bus.rt_used && (bus.ifid_rt == bus.idex_wreg)));

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.halt_wb || bus.dmiss) begin
          // Freeze the whole pipe; halt outranks the data miss.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          state_d = bus.halt_wb ? StHalted : StDwait;
        end else if (load_use) begin
          // Hold PC and IF/ID, inject a bubble into ID/EX, let the load proceed.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (bus.branch_taken) begin
          ifid_flush = 1'b1;
        end else if (bus.imiss) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          state_d    = StIwait;
        end
      end
      StIwait: begin
        if (bus.halt_wb || bus.dmiss) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          state_d = bus.halt_wb ? StHalted : StDwait;
        end else if (bus.idone) begin
          state_d = StRun;
        end else begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      StDwait: begin
        // idone is ignored here; a pending imiss is picked up again in StRun.
        if (bus.halt_wb) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          state_d = StHalted;
        end else if (bus.ddone) begin
          state_d = StRun;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end
      end
      StHalted: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating stall counter; frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!pc_en && (state_q != StHalted) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.idex_en    = idex_en;
  assign bus.exmem_en   = exmem_en;
  assign bus.memwb_en   = memwb_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.halted     = (state_q == StHalted);
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of stall_cnt.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: ifid_rs, ifid_rt  in  4 each  source register numbers held in IF/ID.
REQ-005 Port: rs_used, rt_used  in  1 each  IF/ID instruction reads rs / rt.
REQ-006 Port: idex_memread  in  1  ID/EX holds a load.
REQ-007 Port: idex_wreg  in  4  ID/EX destination register.
REQ-008 Port: branch_taken  in  1  ID resolves a taken branch this cycle.
REQ-009 Port: imiss, dmiss  in  1 each  instruction / data memory busy; held high until the matching done.
REQ-010 Port: idone, ddone  in  1 each  one-cycle completion pulses.
REQ-011 Port: halt_wb  in  1  HLT is valid in MEM/WB.
REQ-012 Port: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch write enables.
REQ-013 Port: ifid_flush, idex_flush  out  1 each  load a bubble into that latch on this edge.
REQ-014 Port: halted  out  1  sticky halt status.
REQ-015 Port: stall_cnt  out  CNT_W  stall-cycle counter.

Function
REQ-016 FSM states SHALL be RUN, IWAIT, DWAIT and HALTED; enables and flushes are combinational from the state and the current inputs.
REQ-017 Default, with no hazard in RUN: all enables 1 and both flushes 0.
REQ-018 Priority SHALL be halt > dmiss > load-use > branch_taken > imiss.
REQ-019 halt_wb=1 in any state SHALL move to HALTED on the next edge; HALTED is left only by rst.
REQ-020 HALTED: all enables 0, both flushes 0, halted=1.
REQ-021 dmiss=1 in RUN or IWAIT: all five enables 0 this cycle; next state DWAIT.
REQ-022 DWAIT: all enables 0 until ddone=1.
REQ-023 On the ddone=1 cycle, all enables are 1; next state RUN.
REQ-024 Load-use: idex_memread=1, idex_wreg!=0, and idex_wreg matches ifid_rs with rs_used=1 or ifid_rt with rt_used=1.
REQ-025 Load-use response: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1, for one cycle; the state stays RUN.
REQ-026 branch_taken=1 with no higher-priority condition: ifid_flush=1, all enables 1.
REQ-027 imiss=1 in RUN with no higher-priority condition: pc_en=0, ifid_flush=1, other enables 1; next state IWAIT.
REQ-028 IWAIT: same outputs as the imiss=1 response in RUN, until idone=1.
REQ-029 On the idone=1 cycle in IWAIT, all enables are 1 and flushes 0; next state RUN.
REQ-030 idone arriving while in DWAIT SHALL be ignored; imiss is re-evaluated in RUN.
REQ-031 stall_cnt SHALL increment by 1 on each edge where pc_en=0 and the state is not HALTED.
REQ-032 stall_cnt SHALL saturate at all-ones (no wrap) and hold its value in HALTED.
REQ-033 ifid_flush and idex_flush SHALL never be 1 in a cycle where that latch's enable is 0.

Reset
REQ-034 rst=1 SHALL asynchronously force state RUN, halted=0 and stall_cnt=0.
REQ-035 With rst=1 and all inputs 0, outputs are all enables 1 and both flushes 0.
REQ-036 rst asserted during DWAIT, IWAIT or HALTED SHALL abandon the wait with no pending state retained.

Verification
REQ-037 Load-use: idex_memread=1, idex_wreg=3, ifid_rs=3, rs_used=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-038 dmiss held 4 cycles, then ddone -> enables 0 for 4 cycles and 1 on the ddone cycle; stall_cnt=4.
REQ-039 imiss held, then dmiss arrives in IWAIT -> DWAIT with all enables 0; after ddone, RUN re-enters IWAIT while imiss=1.
REQ-040 branch_taken=1 with imiss=1 simultaneously -> ifid_flush=1, pc_en=1, state remains RUN.
REQ-041 halt_wb pulse -> halted=1 and all enables 0 permanently; rst mid-HALTED -> halted=0 and enables 1 immediately.
REQ-042 With CNT_W=4, hold dmiss for 20 cycles -> stall_cnt stops at 15.
